// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter slice.
package mult_share_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Bit offset of requester idx inside a packed operand bus of w-bit fields.
    function automatic int op_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester and response channel bundle for mult_share_arbiter.
// master: requester/consumer side, slave: the arbiter.
interface mult_share_arbiter_if
    import mult_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
);

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*W-1:0]    rsp_o;
    logic [IDW-1:0]    rsp_id;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_o, rsp_id
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_o, rsp_id
    );

endinterface

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational grant searching upward from ptr with
// wrap-around; ptr moves just past the winner whenever a grant is taken.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic                     en,
    input  logic                     adv,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  gnt_id
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr;
    logic           found;
    int             idx;

    // Pick the first active request at or after ptr, wrapping past NREQ-1.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = IDW'(idx);
            end
        end
        if (en && found) begin
            grant[gnt_id] = 1'b1;
        end
    end

    // Priority pointer: the winner becomes lowest priority for the next round.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            if (int'(gnt_id) == NREQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_id + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one external combinational W x W multiplier among NREQ requesters.
// Operands are registered toward the multiplier and the product is registered
// toward a single tagged response channel.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_share_arbiter_if.slave  bus,
    output logic [W-1:0]         m_x,
    output logic [W-1:0]         m_y,
    input  logic [2*W-1:0]       m_o
);

    localparam int IDW = $clog2(NREQ);

    state_t          state;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  gnt_id;
    logic [NREQ-1:0] grant;
    logic            grant_en;
    logic            accept;
    logic [W-1:0]    sel_x;
    logic [W-1:0]    sel_y;
    logic            rsp_valid_q;
    logic [2*W-1:0]  rsp_o_q;
    logic [IDW-1:0]  rsp_id_q;

    // Grants open in IDLE, or in RESP only while the consumer is taking the
    // current product, so a new operand never overwrites an unread result.
    always_comb begin
        grant_en = !rst && ((state == IDLE) || ((state == RESP) && bus.rsp_ready));
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .en     (grant_en),
        .adv    (accept),
        .grant  (grant),
        .gnt_id (gnt_id)
    );

    assign accept        = |grant;
    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_o     = rsp_o_q;
    assign bus.rsp_id    = rsp_id_q;

    // Route the granted requester's operands toward the operand registers.
    always_comb begin
        sel_x = bus.req_x[op_lsb(int'(gnt_id), W) +: W];
        sel_y = bus.req_y[op_lsb(int'(gnt_id), W) +: W];
    end

    // Control FSM with operand and result registers; m_x/m_y only move on an
    // accept so the multiplier sees stable inputs for the whole CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            m_x         <= '0;
            m_y         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_o_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_x   <= sel_x;
                        m_y   <= sel_y;
                        id_q  <= gnt_id;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rsp_o_q     <= m_o;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (accept) begin
                            m_x   <= sel_x;
                            m_y   <= sel_y;
                            id_q  <= gnt_id;
                            state <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a behavioural multiplier
// and a scoreboard of expected {product, id} pushed at each accept.
module tb_mult_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;

    typedef struct packed {
        logic [7:0] p;
        logic [1:0] id;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] m_x;
    logic [3:0] m_y;
    logic [7:0] m_o;

    int   total;
    int   passed;
    bit   oneshot;
    logic [3:0] acc_edge;
    exp_t exp_q[$];
    int   gnt_log[$];

    mult_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    mult_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .m_x (m_x),
        .m_y (m_y),
        .m_o (m_o)
    );

    assign m_o = {4'b0, m_x} * {4'b0, m_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record accepts and push the expected product for each one.
    always @(posedge clk) begin
        acc_edge = bus.req_valid & bus.req_ready;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc_edge[i]) begin
                    exp_q.push_back({{4'b0, bus.req_x[i*4 +: 4]} * {4'b0, bus.req_y[i*4 +: 4]}, 2'(i)});
                    gnt_log.push_back(i);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (oneshot) bus.req_valid = bus.req_valid & ~acc_edge;
    endtask

    task automatic set_op(input int i, input logic [3:0] x, input logic [3:0] y);
        bus.req_x[i*4 +: 4] = x;
        bus.req_y[i*4 +: 4] = y;
    endtask

    task automatic pop_exp(output exp_t e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = {8'hff, 2'b11};
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.rsp_valid && bus.rsp_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        oneshot = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        gnt_log.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        oneshot = 1'b0;
        step();
        step();
        total++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", bus.req_ready); else passed++;
        total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else passed++;
        total++; if ({bus.rsp_o, bus.rsp_id, m_x, m_y} !== 18'd0) $display("FAIL reset_outputs: got rsp_o=%0d id=%0d m_x=%0d m_y=%0d want 0", bus.rsp_o, bus.rsp_id, m_x, m_y); else passed++;
        apply_reset();
        step();
        total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_idle_quiet: got %b want 0", bus.rsp_valid); else passed++;
    endtask

    task automatic test_single();
        exp_t e;
        apply_reset();
        set_op(0, 4'd3, 4'd5);
        bus.req_valid = 4'b0001;
        #1;
        total++; if (bus.req_ready !== 4'b0001) $display("FAIL t1_ready: got %b want 0001", bus.req_ready); else passed++;
        step();
        total++; if (bus.rsp_valid !== 1'b0) $display("FAIL t1_calc_valid: got %b want 0", bus.rsp_valid); else passed++;
        step();
        total++; if (bus.rsp_valid !== 1'b1) $display("FAIL t1_rsp_valid: got %b want 1", bus.rsp_valid); else passed++;
        pop_exp(e);
        total++; if (bus.rsp_o !== e.p || bus.rsp_o !== 8'd15) $display("FAIL t1_product: got %0d want %0d", bus.rsp_o, e.p); else passed++;
        total++; if (bus.rsp_id !== e.id || bus.rsp_id !== 2'd0) $display("FAIL t1_id: got %0d want %0d", bus.rsp_id, e.id); else passed++;
        bus.rsp_ready = 1'b1;
        step();
        total++; if (bus.rsp_valid !== 1'b0) $display("FAIL t1_drain: got %b want 0", bus.rsp_valid); else passed++;
        #1;
        bus.req_valid = 4'b0010;
        set_op(1, 4'd1, 4'd1);
        #1;
        total++; if (bus.req_ready !== 4'b0010) $display("FAIL t1_back_idle: got %b want 0010", bus.req_ready); else passed++;
        bus.req_valid = '0;
    endtask

    task automatic test_all_four();
        exp_t e;
        bit ok;
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 4'(i + 1), 4'd2);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0001) $display("FAIL t2_first_grant: got %b want 0001", bus.req_ready); else passed++;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(ok);
            total++; if (!ok) $display("FAIL t2_timeout: got 0 responses-in-budget want 1 (k=%0d)", k); else passed++;
            pop_exp(e);
            total++; if (bus.rsp_o !== e.p || bus.rsp_o !== 8'(2 * (k + 1))) $display("FAIL t2_product: got %0d want %0d", bus.rsp_o, 2 * (k + 1)); else passed++;
            total++; if (bus.rsp_id !== e.id || bus.rsp_id !== 2'(k)) $display("FAIL t2_id: got %0d want %0d", bus.rsp_id, k); else passed++;
        end
        total++; if (gnt_log.size() !== 4) $display("FAIL t2_grant_count: got %0d want 4", gnt_log.size()); else passed++;
        for (int k = 0; k < gnt_log.size() && k < 4; k++) begin
            total++; if (gnt_log[k] !== k) $display("FAIL t2_grant_order: got %0d want %0d", gnt_log[k], k); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int got;
        int first_hi;
        int second_hi;
        apply_reset();
        set_op(1, 4'd15, 4'd15);
        set_op(2, 4'd7, 4'd9);
        bus.req_valid = 4'b0110;
        bus.rsp_ready = 1'b1;
        got = 0;
        first_hi = -1;
        second_hi = -1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.rsp_valid) begin
                if (first_hi < 0) first_hi = c;
                else if (second_hi < 0) second_hi = c;
                pop_exp(e);
                got++;
                total++; if (bus.rsp_o !== e.p || bus.rsp_o !== (got == 1 ? 8'd225 : 8'd63)) $display("FAIL t3_product: got %0d want %0d", bus.rsp_o, (got == 1 ? 225 : 63)); else passed++;
                total++; if (bus.rsp_id !== e.id || bus.rsp_id !== (got == 1 ? 2'd1 : 2'd2)) $display("FAIL t3_id: got %0d want %0d", bus.rsp_id, (got == 1 ? 1 : 2)); else passed++;
            end
        end
        total++; if (got !== 2) $display("FAIL t3_count: got %0d want 2", got); else passed++;
        total++; if (second_hi - first_hi !== 2) $display("FAIL t3_gap: got %0d want 2", second_hi - first_hi); else passed++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit ok;
        bit stable;
        logic [7:0] held_o;
        logic [1:0] held_id;
        apply_reset();
        set_op(0, 4'd2, 4'd3);
        set_op(3, 4'd4, 4'd4);
        bus.req_valid = 4'b0001;
        step();
        step();
        held_o = bus.rsp_o;
        held_id = bus.rsp_id;
        bus.req_valid = 4'b1000;
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1 || bus.rsp_o !== held_o || bus.rsp_id !== held_id) stable = 1'b0;
            step();
        end
        total++; if (!stable) $display("FAIL t4_hold: got changing outputs or ready=%b want stable, ready 0000", bus.req_ready); else passed++;
        total++; if (gnt_log.size() !== 1) $display("FAIL t4_no_accept: got %0d grants want 1", gnt_log.size()); else passed++;
        bus.rsp_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b1000) $display("FAIL t4_release_ready: got %b want 1000", bus.req_ready); else passed++;
        pop_exp(e);
        total++; if (bus.rsp_o !== e.p || bus.rsp_o !== 8'd6) $display("FAIL t4_first_product: got %0d want %0d", bus.rsp_o, e.p); else passed++;
        total++; if (bus.rsp_id !== e.id) $display("FAIL t4_first_id: got %0d want %0d", bus.rsp_id, e.id); else passed++;
        wait_rsp(ok);
        total++; if (!ok) $display("FAIL t4_timeout: got 0 want 1"); else passed++;
        pop_exp(e);
        total++; if (bus.rsp_o !== e.p || bus.rsp_o !== 8'd16) $display("FAIL t4_second_product: got %0d want 16", bus.rsp_o); else passed++;
        total++; if (bus.rsp_id !== e.id || bus.rsp_id !== 2'd3) $display("FAIL t4_second_id: got %0d want 3", bus.rsp_id); else passed++;
    endtask

    task automatic test_fairness();
        exp_t e;
        bit ok;
        apply_reset();
        oneshot = 1'b0;
        set_op(0, 4'd1, 4'd1);
        set_op(2, 4'd2, 4'd2);
        bus.req_valid = 4'b0101;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_rsp(ok);
            total++; if (!ok) $display("FAIL t5_timeout: got 0 want 1 (k=%0d)", k); else passed++;
            pop_exp(e);
            total++; if (bus.rsp_id !== e.id || bus.rsp_id !== 2'((k % 2) * 2)) $display("FAIL t5_alternate: got %0d want %0d", bus.rsp_id, (k % 2) * 2); else passed++;
            total++; if (bus.rsp_o !== e.p) $display("FAIL t5_product: got %0d want %0d", bus.rsp_o, e.p); else passed++;
        end
        oneshot = 1'b1;
    endtask

    task automatic test_reset_in_calc();
        exp_t e;
        bit ok;
        bit quiet;
        apply_reset();
        set_op(1, 4'd5, 4'd5);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        total++; if (bus.rsp_valid !== 1'b0) $display("FAIL t6_rsp_valid: got %b want 0", bus.rsp_valid); else passed++;
        total++; if ({bus.rsp_o, bus.rsp_id, m_x, m_y} !== 18'd0) $display("FAIL t6_outputs: got rsp_o=%0d id=%0d m_x=%0d m_y=%0d want 0", bus.rsp_o, bus.rsp_id, m_x, m_y); else passed++;
        set_op(1, 4'd1, 4'd2);
        set_op(2, 4'd3, 4'd3);
        bus.req_valid = 4'b0110;
        #1;
        total++; if (bus.req_ready !== 4'b0000) $display("FAIL t6_ready_in_reset: got %b want 0000", bus.req_ready); else passed++;
        exp_q.delete();
        gnt_log.delete();
        rst = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b0010) $display("FAIL t6_ptr_reset: got %b want 0010", bus.req_ready); else passed++;
        for (int k = 0; k < 2; k++) begin
            wait_rsp(ok);
            total++; if (!ok) $display("FAIL t6_timeout: got 0 want 1 (k=%0d)", k); else passed++;
            pop_exp(e);
            total++; if (bus.rsp_o !== e.p || bus.rsp_o !== (k == 0 ? 8'd2 : 8'd9)) $display("FAIL t6_product: got %0d want %0d", bus.rsp_o, (k == 0 ? 2 : 9)); else passed++;
            total++; if (bus.rsp_id !== e.id || bus.rsp_id !== 2'(k + 1)) $display("FAIL t6_id: got %0d want %0d", bus.rsp_id, k + 1); else passed++;
        end
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.rsp_valid !== 1'b0) quiet = 1'b0;
        end
        total++; if (!quiet) $display("FAIL t6_no_stale: got extra response want none"); else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        oneshot = 1'b1;
        acc_edge = '0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_back_to_back();
        test_backpressure();
        test_fairness();
        test_reset_in_calc();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
